spi_stream_arbiter: RTL and testbench
=====================================

# spi_stream_arbiter

Shares the single SPI data stream from the storage card between the video frame-buffer refill path and the audio sample FIFO. Grants bursts to one requester at a time, drives chip_select and the SPI clock enable, deserializes MISO bits (already synchronized into the CLK_40 domain) into bytes, and routes each byte to the granted sink. Sits between the CDC front end (MISO/SPI clock synchronizers) and the video/audio write logic, under control of the mode FSM via `pause`.

## Interface
Parameters:
- VIDEO_BURST_BYTES, 64: bytes per video grant (1..1023).
- AUDIO_BURST_BYTES, 16: bytes per audio grant (1..1023).
- MAX_VIDEO_STREAK, 4: consecutive video grants allowed while audio_req is high before audio is forced.
- CS_GAP_CYCLES, 8: CLK_40 cycles chip_select stays high between bursts, and setup cycles after assert.

Ports:
- CLK_40  in  1  sole clock, 40 MHz.
- reset  in  1  asynchronous, active-low reset.
- init  in  1  one-cycle pulse; arms arbiter after reset.
- pause  in  1  level; finish current byte then hold.
- video_req  in  1  level; video sink has room for a full burst.
- audio_req  in  1  level; audio sink has room for a full burst.
- SPI_clk_rising_edge  in  1  one-cycle pulse per synchronized SPI rising edge.
- received_bit  in  1  synchronized MISO, valid on SPI_clk_rising_edge.
- chip_select  out  1  active-low card select.
- SPI_clk_en  out  1  enables SPI clock generation.
- byte_data  out  8  assembled byte, MSB first.
- write_video  out  1  one-cycle strobe: byte_data to video.
- write_audio  out  1  one-cycle strobe: byte_data to audio.
- video_grant / audio_grant  out  1 each  current burst owner.
- burst_done  out  1  one-cycle pulse after last byte of a burst.

## Operation
- States: DISARMED, IDLE, SETUP, XFER, GAP, HOLD.
- Reset (async, low): state DISARMED; chip_select=1, SPI_clk_en=0, byte_data=0, all strobes/grants 0, streak=0, bit/byte counters 0.
- DISARMED -> IDLE on init. init in any other state ignored.
- IDLE: if pause, stay. Else arbitrate: audio_req && (streak>=MAX_VIDEO_STREAK || !video_req) -> audio; else video_req -> video; else audio_req -> audio; none -> stay. Grant latches; chip_select=0; -> SETUP.
- SETUP: count CS_GAP_CYCLES, then SPI_clk_en=1, -> XFER.
- XFER: each SPI_clk_rising_edge shifts received_bit into shift register LSB; on 8th bit, byte_data loads, strobe for owner pulses, byte counter increments. On last byte of burst: SPI_clk_en=0, chip_select=1, burst_done, grants clear, -> GAP. If pause seen at a byte boundary: SPI_clk_en=0, -> HOLD (chip_select stays 0).
- HOLD: on pause low, SPI_clk_en=1, -> XFER, counters preserved.
- GAP: CS_GAP_CYCLES cycles, -> IDLE.
- Streak: video grant increments (saturating at MAX_VIDEO_STREAK); audio grant clears it.
- Requests are sampled only in IDLE; deasserting a request mid-burst does not shorten the burst.
- SPI_clk_rising_edge outside XFER ignored; partial-bit counter only resets at burst start.

## Timing
- Byte latency: strobe and byte_data valid the cycle after the 8th SPI_clk_rising_edge; byte_data holds until next byte.
- burst_done coincident with final write strobe.
- Request-to-first-edge-enable: 1 (IDLE) + CS_GAP_CYCLES cycles.
- Minimum inter-burst chip_select high: CS_GAP_CYCLES cycles.
- Simultaneous video_req and audio_req with streak<MAX: video wins.
- pause asserted mid-byte: byte completes first; pause and last-byte coincident: burst ends normally, pause applied in IDLE.
- reset mid-burst: immediate return to DISARMED; partial byte discarded, no strobe.

## Configuration
- STREAM_ARB_AUDIO_EN defined: audio arbitration, write_audio, audio_grant and streak logic present as above.
- Not defined: audio_req ignored, write_audio and audio_grant tied 0, streak counter removed; video served whenever video_req.

## Structure
- Shared package bad_apple_pkg: arbiter state enum, grant-owner enum, SPI_BITS_PER_BYTE=8 constant.
- One sub-module: spi_byte_shifter (bit counter, shift register, byte-valid pulse, clear input).

## Test plan
- Reset low mid-XFER after 3 bits -> chip_select=1, SPI_clk_en=0, no strobe, state DISARMED; no activity until init.
- init, video_req=1 only, feed 64 bytes 0x00,0x01..0x3F -> 64 write_video pulses with matching byte_data, burst_done on 64th, chip_select high 8 cycles.
- Both requests held, MAX_VIDEO_STREAK=4 -> grant order V,V,V,V,A,V,V,V,V,A.
- Bits 1,0,1,1,1,0,1,1 -> byte_data=0xBB one cycle after 8th edge.
- pause high after 3 bits of byte 5 -> byte 5 completes, HOLD with chip_select=0, resumes at byte 6 on pause low; 64 total bytes.
- STREAM_ARB_AUDIO_EN undefined, audio_req=1, video_req=0 -> no grants, chip_select stays 1.

Source files
------------

// File: rtl/bad_apple_pkg.sv
// Shared types for the SD-card stream path: arbiter states, burst owners and
// SPI framing constants.
package bad_apple_pkg;

  localparam int SPI_BITS_PER_BYTE = 8;

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_IDLE     = 3'd1,
    ST_SETUP    = 3'd2,
    ST_XFER     = 3'd3,
    ST_GAP      = 3'd4,
    ST_HOLD     = 3'd5
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_VIDEO = 2'd1,
    OWN_AUDIO = 2'd2
  } owner_e;

endpackage

// File: rtl/spi_byte_shifter.sv
// MSB-first deserializer: collects SPI_BITS_PER_BYTE qualified bits and flags
// the edge that completes a byte; clear drops any partial byte.
module spi_byte_shifter
  import bad_apple_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         bit_valid,
  input  logic                         bit_in,
  output logic [SPI_BITS_PER_BYTE-1:0] byte_o,
  output logic                         byte_valid_o
);

  localparam int CW = $clog2(SPI_BITS_PER_BYTE);

  logic [SPI_BITS_PER_BYTE-2:0] shift_q, shift_d;
  logic [CW-1:0]                cnt_q, cnt_d;

  // byte_o is only meaningful in the cycle byte_valid_o is high.
  assign byte_o       = {shift_q, bit_in};
  assign byte_valid_o = bit_valid && !clear && (cnt_q == CW'(SPI_BITS_PER_BYTE - 1));

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (bit_valid) begin
      shift_d = byte_o[SPI_BITS_PER_BYTE-2:0];
      cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_stream_arbiter.sv
// Burst arbiter sharing the SD-card SPI stream between video refill and audio
// FIFO. Audio arbitration is built only when STREAM_ARB_AUDIO_EN is defined.
module spi_stream_arbiter
  import bad_apple_pkg::*;
#(
  parameter int VIDEO_BURST_BYTES = 64,
  parameter int AUDIO_BURST_BYTES = 16,
  parameter int MAX_VIDEO_STREAK  = 4,
  parameter int CS_GAP_CYCLES     = 8
) (
  input  logic       CLK_40,
  input  logic       reset,
  input  logic       init,
  input  logic       pause,
  input  logic       video_req,
  input  logic       audio_req,
  input  logic       SPI_clk_rising_edge,
  input  logic       received_bit,
  output logic       chip_select,
  output logic       SPI_clk_en,
  output logic [7:0] byte_data,
  output logic       write_video,
  output logic       write_audio,
  output logic       video_grant,
  output logic       audio_grant,
  output logic       burst_done,
  output arb_state_e dbg_state
);

  arb_state_e  state_q, state_d;
  owner_e      owner_q, owner_d;
  logic        cs_q, cs_d, en_q, en_d, wv_q, wv_d, done_q, done_d;
  logic [7:0]  byte_data_q, byte_data_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [9:0]  byte_cnt_q, byte_cnt_d, burst_len;
  logic        pick_video, pick_audio;
  logic [7:0]  sh_byte;
  logic        sh_valid;

  spi_byte_shifter u_shifter (
    .clk          (CLK_40),
    .rst_n        (reset),
    .clear        (state_q == ST_IDLE),
    .bit_valid    (SPI_clk_rising_edge && (state_q == ST_XFER)),
    .bit_in       (received_bit),
    .byte_o       (sh_byte),
    .byte_valid_o (sh_valid)
  );

`ifdef STREAM_ARB_AUDIO_EN
  logic [7:0] streak_q, streak_d;
  logic       wa_q, wa_d;

  assign pick_audio  = audio_req && ((streak_q >= 8'(MAX_VIDEO_STREAK)) || !video_req);
  assign pick_video  = video_req && !pick_audio;
  assign write_audio = wa_q;
  assign audio_grant = (owner_q == OWN_AUDIO);
`else
  logic [7:0] unused_cfg;

  assign unused_cfg  = {audio_req, 7'(MAX_VIDEO_STREAK)};
  assign pick_audio  = 1'b0;
  assign pick_video  = video_req;
  assign write_audio = 1'b0;
  assign audio_grant = 1'b0;
`endif

  assign burst_len   = (owner_q == OWN_AUDIO) ? 10'(AUDIO_BURST_BYTES) : 10'(VIDEO_BURST_BYTES);
  assign chip_select = cs_q;
  assign SPI_clk_en  = en_q;
  assign byte_data   = byte_data_q;
  assign write_video = wv_q;
  assign video_grant = (owner_q == OWN_VIDEO);
  assign burst_done  = done_q;
  assign dbg_state   = state_q;

  // write_video/write_audio are one-cycle valids with no ready: a request is
  // only granted when its sink can take the whole burst.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cs_d        = cs_q;
    en_d        = en_q;
    byte_data_d = byte_data_q;
    gap_cnt_d   = gap_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    wv_d        = 1'b0;
    done_d      = 1'b0;
`ifdef STREAM_ARB_AUDIO_EN
    streak_d    = streak_q;
    wa_d        = 1'b0;
`endif
    case (state_q)
      ST_DISARMED: if (init) state_d = ST_IDLE;
      ST_IDLE: begin
        if (!pause && (pick_video || pick_audio)) begin
          owner_d    = pick_audio ? OWN_AUDIO : OWN_VIDEO;
          cs_d       = 1'b0;
          gap_cnt_d  = '0;
          byte_cnt_d = '0;
          state_d    = ST_SETUP;
`ifdef STREAM_ARB_AUDIO_EN
          if (pick_audio) streak_d = '0;
          else if (streak_q < 8'(MAX_VIDEO_STREAK)) streak_d = streak_q + 8'd1;
`endif
        end
      end
      ST_SETUP: begin
        if (gap_cnt_q == 16'(CS_GAP_CYCLES - 1)) begin
          gap_cnt_d = '0;
          en_d      = 1'b1;
          state_d   = ST_XFER;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      ST_XFER: begin
        if (sh_valid) begin
          byte_data_d = sh_byte;
          wv_d        = (owner_q == OWN_VIDEO);
`ifdef STREAM_ARB_AUDIO_EN
          wa_d        = (owner_q == OWN_AUDIO);
`endif
          byte_cnt_d  = byte_cnt_q + 10'd1;
          // A last byte wins over pause; pause is then honoured in IDLE.
          if (byte_cnt_q + 10'd1 == burst_len) begin
            en_d      = 1'b0;
            cs_d      = 1'b1;
            done_d    = 1'b1;
            owner_d   = OWN_NONE;
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end else if (pause) begin
            en_d    = 1'b0;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!pause) begin
          en_d    = 1'b1;
          state_d = ST_XFER;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 16'(CS_GAP_CYCLES - 1)) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_DISARMED;
    endcase
  end

  always_ff @(posedge CLK_40 or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_DISARMED;
      owner_q     <= OWN_NONE;
      cs_q        <= 1'b1;
      en_q        <= 1'b0;
      byte_data_q <= '0;
      gap_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      wv_q        <= 1'b0;
      done_q      <= 1'b0;
`ifdef STREAM_ARB_AUDIO_EN
      streak_q    <= '0;
      wa_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cs_q        <= cs_d;
      en_q        <= en_d;
      byte_data_q <= byte_data_d;
      gap_cnt_q   <= gap_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      wv_q        <= wv_d;
      done_q      <= done_d;
`ifdef STREAM_ARB_AUDIO_EN
      streak_q    <= streak_d;
      wa_q        <= wa_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_stream_arbiter.sv
// Directed bench for spi_stream_arbiter; the audio section follows
// STREAM_ARB_AUDIO_EN.
module tb_spi_stream_arbiter;
  import bad_apple_pkg::*;

  logic       CLK_40 = 1'b0;
  logic       reset, init, pause, video_req, audio_req, spi_edge, rbit;
  logic       chip_select, SPI_clk_en, write_video, write_audio;
  logic       video_grant, audio_grant, burst_done;
  logic [7:0] byte_data;
  arb_state_e dbg_state;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int wv_total = 0;
  int wa_total = 0;
  logic [7:0] exp_q[$];

  // clock / reset
  always #5 CLK_40 = ~CLK_40;

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  spi_stream_arbiter dut (
    .CLK_40              (CLK_40),
    .reset               (reset),
    .init                (init),
    .pause               (pause),
    .video_req           (video_req),
    .audio_req           (audio_req),
    .SPI_clk_rising_edge (spi_edge),
    .received_bit        (rbit),
    .chip_select         (chip_select),
    .SPI_clk_en          (SPI_clk_en),
    .byte_data           (byte_data),
    .write_video         (write_video),
    .write_audio         (write_audio),
    .video_grant         (video_grant),
    .audio_grant         (audio_grant),
    .burst_done          (burst_done),
    .dbg_state           (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every strobe must match the next expected byte
  always @(negedge CLK_40) begin
    if (write_video || write_audio) begin
      if (write_video) wv_total++;
      if (write_audio) wa_total++;
      if (exp_q.size() == 0) check("unexpected_strobe", 32'd1, 32'd0);
      else check("sb_byte_data", {24'd0, byte_data}, {24'd0, exp_q.pop_front()});
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK_40);
    #1;
  endtask

  task automatic pulse_edge(input logic b);
    rbit     = b;
    spi_edge = 1'b1;
    tick();
    spi_edge = 1'b0;
  endtask

  task automatic wait_en(input string tag);
    int n = 0;
    while (!SPI_clk_en && n < 60) begin
      tick();
      n++;
    end
    check(tag, {31'd0, SPI_clk_en}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_v, input logic exp_a,
                           input logic last, input logic pause_mid);
    exp_q.push_back(b);
    for (int k = 7; k >= 0; k--) begin
      pulse_edge(b[k]);
      if (pause_mid && k == 5) pause = 1'b1;
      if (k != 0) tick();
    end
    check("write_video", {31'd0, write_video}, {31'd0, exp_v});
    check("write_audio", {31'd0, write_audio}, {31'd0, exp_a});
    check("burst_done", {31'd0, burst_done}, {31'd0, last});
    if (last) begin
      check("cs_after_last", {31'd0, chip_select}, 32'd1);
      check("grant_after_last", {30'd0, video_grant, audio_grant}, 32'd0);
      check("en_after_last", {31'd0, SPI_clk_en}, 32'd0);
    end
    if (pause_mid) begin
      check("hold_state", {29'd0, dbg_state}, {29'd0, ST_HOLD});
      check("hold_cs", {31'd0, chip_select}, 32'd0);
      check("hold_en", {31'd0, SPI_clk_en}, 32'd0);
    end
    tick();
    check("strobe_one_cycle", {31'd0, write_video | write_audio}, 32'd0);
    check("byte_data_hold", {24'd0, byte_data}, {24'd0, b});
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b0; init = 1'b0; pause = 1'b0; video_req = 1'b0; audio_req = 1'b0;
    spi_edge = 1'b0; rbit = 1'b0;
    repeat (3) tick();

    // reset values
    check("rst_cs", {31'd0, chip_select}, 32'd1);
    check("rst_en", {31'd0, SPI_clk_en}, 32'd0);
    check("rst_byte", {24'd0, byte_data}, 32'd0);
    check("rst_strobes", {30'd0, write_video, write_audio}, 32'd0);
    check("rst_grants", {30'd0, video_grant, audio_grant}, 32'd0);
    check("rst_done", {31'd0, burst_done}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, {29'd0, ST_DISARMED});

    // requests without init do nothing
    reset = 1'b1;
    video_req = 1'b1;
    repeat (20) tick();
    check("no_init_cs", {31'd0, chip_select}, 32'd1);
    check("no_init_state", {29'd0, dbg_state}, {29'd0, ST_DISARMED});

    // init, then exact grant-to-enable latency
    init = 1'b1; tick(); init = 1'b0;
    check("armed_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    tick();
    check("grant_cs", {31'd0, chip_select}, 32'd0);
    check("grant_video", {31'd0, video_grant}, 32'd1);
    check("setup_state", {29'd0, dbg_state}, {29'd0, ST_SETUP});
    repeat (7) tick();
    check("setup_en_low", {31'd0, SPI_clk_en}, 32'd0);
    tick();
    check("setup_en_high", {31'd0, SPI_clk_en}, 32'd1);
    check("xfer_state", {29'd0, dbg_state}, {29'd0, ST_XFER});

    // reset after 3 bits of the first byte
    for (int k = 0; k < 3; k++) begin pulse_edge(1'b1); tick(); end
    reset = 1'b0;
    #1;
    check("midrst_cs", {31'd0, chip_select}, 32'd1);
    check("midrst_en", {31'd0, SPI_clk_en}, 32'd0);
    check("midrst_state", {29'd0, dbg_state}, {29'd0, ST_DISARMED});
    check("midrst_grant", {31'd0, video_grant}, 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (10) tick();
    check("midrst_idle_cs", {31'd0, chip_select}, 32'd1);
    check("midrst_no_strobe", wv_total, 32'd0);

    // burst 1: 0x00..0x3F; request dropped mid-burst must not shorten it
    init = 1'b1; tick(); init = 1'b0;
    wait_en("en_burst1");
    check("b1_grant", {31'd0, video_grant}, 32'd1);
    for (int i = 0; i < 64; i++) begin
      if (i == 10) video_req = 1'b0;
      send_byte(8'(i), 1'b1, 1'b0, i == 63, 1'b0);
    end
    video_req = 1'b1;
    for (int j = 0; j < 7; j++) begin
      check("gap_cs_high", {31'd0, chip_select}, 32'd1);
      tick();
    end
    check("gap_end_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("gap_end_cs", {31'd0, chip_select}, 32'd1);
    tick();
    check("b2_cs_low", {31'd0, chip_select}, 32'd0);
    check("b2_grant", {31'd0, video_grant}, 32'd1);

    // burst 2: first byte is bits 1,0,1,1,1,0,1,1
    wait_en("en_burst2");
    send_byte(8'hBB, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 64; i++) send_byte(8'(i * 3 + 7), 1'b1, 1'b0, i == 63, 1'b0);

    // burst 3: pause raised 3 bits into the fifth byte
    wait_en("en_burst3");
    for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + i), 1'b1, 1'b0, 1'b0, i == 4);
    pulse_edge(1'b1);
    repeat (5) tick();
    check("hold_stays", {29'd0, dbg_state}, {29'd0, ST_HOLD});
    check("hold_cs_low", {31'd0, chip_select}, 32'd0);
    pause = 1'b0;
    tick();
    check("resume_en", {31'd0, SPI_clk_en}, 32'd1);
    check("resume_state", {29'd0, dbg_state}, {29'd0, ST_XFER});
    for (int i = 5; i < 64; i++) begin
      if (i == 63) video_req = 1'b0;
      send_byte(8'(8'h40 + i), 1'b1, 1'b0, i == 63, 1'b0);
    end
    check("video_total", wv_total, 32'd192);

    // pause in IDLE holds off arbitration
    pause = 1'b1;
    video_req = 1'b1;
    repeat (30) tick();
    check("pause_idle_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("pause_idle_cs", {31'd0, chip_select}, 32'd1);
    pause = 1'b0;
    tick();
    check("unpause_grant", {31'd0, video_grant}, 32'd1);
    video_req = 1'b0;
    do_reset();
    init = 1'b1; tick(); init = 1'b0;

`ifdef STREAM_ARB_AUDIO_EN
    // both requests held: V,V,V,V,A,V,V,V,V,A
    video_req = 1'b1;
    audio_req = 1'b1;
    for (int b = 0; b < 10; b++) begin
      logic is_a;
      int   n;
      is_a = (b % 5 == 4);
      n    = is_a ? 16 : 64;
      wait_en("en_streak");
      check("streak_vgrant", {31'd0, video_grant}, {31'd0, !is_a});
      check("streak_agrant", {31'd0, audio_grant}, {31'd0, is_a});
      for (int i = 0; i < n; i++) begin
        if (b == 9 && i == n - 1) begin video_req = 1'b0; audio_req = 1'b0; end
        send_byte(8'(b * 16 + i), !is_a, is_a, i == n - 1, 1'b0);
      end
    end
    check("audio_total", wa_total, 32'd32);
`else
    // audio_req alone never produces a grant
    audio_req = 1'b1;
    video_req = 1'b0;
    repeat (40) tick();
    check("noaudio_cs", {31'd0, chip_select}, 32'd1);
    check("noaudio_grants", {30'd0, video_grant, audio_grant}, 32'd0);
    check("noaudio_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("noaudio_strobes", wa_total, 32'd0);
    audio_req = 1'b0;
`endif

    repeat (5) tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);

    // report
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
